ahb_ram_ctrl: RTL and testbench

//  - AHB-Lite slave front-end that sequences the 64-byte data RAM (ram_ahb).
//  - Captures AHB address phases and drives the RAM's sel_1 / rd_en_ram / wr_en_ram /

---
 rtl/ahb_ram_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ahb_ram_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_ram_ctrl.sv
// ahb_ram_ctrl: AHB-Lite slave front-end for the 64-byte data RAM (ram_ahb).
//
// Captures accepted AHB address phases and sequences the RAM strobes in the
// matching data phase. Reads take one wait state because the RAM output is
// registered. Writes take none. Illegal transfers never reach the RAM.
//
// Optional feature macro: AHB_RAM_ERR_RESP_EN
//   defined   : an illegal transfer gets a two-cycle AHB ERROR response (ERR1, ERR2).
//   undefined : an illegal transfer is dropped and gets one OKAY cycle; hresp is tied to 0.
//
// Ports
//   clk, reset_n                 clock and asynchronous active-low reset
//   hsel, haddr, htrans, hwrite  AHB address phase from the decoder
//   hsize, hready                AHB address phase from the decoder
//   hwdata                       AHB write data (data phase)
//   hreadyout, hresp, hrdata     AHB slave response
//   sel_1, rd_en_ram, wr_en_ram  RAM strobes
//   address_ram, ram_hsize       captured RAM address and access size
//   wr_data                      RAM write data
//   rd_data                      RAM read data (valid the cycle after rd_en_ram)
module ahb_ram_ctrl #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata,
    output logic        sel_1,
    output logic        rd_en_ram,
    output logic        wr_en_ram,
    output logic [31:0] address_ram,
    output logic [2:0]  ram_hsize,
    output logic [31:0] wr_data,
    input  logic [31:0] rd_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RDW,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    state_t              w_accept_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_size;
    logic                w_accept;
    logic                w_can_take;
    logic                w_take;
    logic                w_size_ok;
    logic                w_range_ok;
    logic                w_align_ok;
    logic                w_legal;
    logic                w_unused;

    // htrans[0] only separates BUSY from IDLE and NONSEQ from SEQ; neither matters here.
    assign w_unused = htrans[0];

    // Address-phase qualification and legality.
    assign w_accept   = hsel & hready & htrans[1];
    assign w_can_take = (r_state != ST_RD) && (r_state != ST_ERR1);
    assign w_take     = w_accept & w_can_take;
    assign w_size_ok  = (hsize <= 3'd2);
    assign w_range_ok = (haddr[31:ADDR_W] == '0);
    assign w_align_ok = !(((hsize == 3'd1) && haddr[0]) ||
                          ((hsize == 3'd2) && (haddr[1:0] != 2'b00)));
    assign w_legal    = w_size_ok & w_range_ok & w_align_ok;

    // Where an accepted transfer goes for its data phase.
    always_comb begin
        w_accept_state = ST_IDLE;
        if (w_legal) begin
            w_accept_state = hwrite ? ST_WR : ST_RD;
        end else begin
`ifdef AHB_RAM_ERR_RESP_EN
            w_accept_state = ST_ERR1;
`else
            w_accept_state = ST_IDLE;
`endif
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Captured address and size; held between transfers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr <= '0;
            r_size <= '0;
        end else if (w_take) begin
            r_addr <= haddr[ADDR_W-1:0];
            r_size <= hsize;
        end
    end

    assign address_ram = 32'(r_addr);
    assign ram_hsize   = r_size;

    // Next state and data-phase outputs, decoded from the current state.
    always_comb begin
        w_next    = ST_IDLE;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        sel_1     = 1'b0;
        rd_en_ram = 1'b0;
        wr_en_ram = 1'b0;
        wr_data   = '0;
        case (r_state)
            ST_WR: begin
                sel_1     = 1'b1;
                wr_en_ram = 1'b1;
                wr_data   = hwdata;
                if (w_accept) w_next = w_accept_state;
            end
            ST_RD: begin
                // RAM registers the read at the end of this cycle.
                sel_1     = 1'b1;
                rd_en_ram = 1'b1;
                hreadyout = 1'b0;
                w_next    = ST_RDW;
            end
            ST_RDW: begin
                hrdata = rd_data;
                if (w_accept) w_next = w_accept_state;
            end
`ifdef AHB_RAM_ERR_RESP_EN
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                w_next    = ST_ERR2;
            end
            ST_ERR2: begin
                hresp = 1'b1;
                if (w_accept) w_next = w_accept_state;
            end
`endif
            default: begin
                if (w_accept) w_next = w_accept_state;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_ram_ctrl.sv
// tb_ahb_ram_ctrl: directed bench for ahb_ram_ctrl with a behavioural RAM (ram_ahb stand-in)
// and a transfer-level model that predicts every data-phase cycle of the slave outputs.
module tb_ahb_ram_ctrl;

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        sel_1;
    logic        rd_en_ram;
    logic        wr_en_ram;
    logic [31:0] address_ram;
    logic [2:0]  ram_hsize;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    ahb_ram_ctrl #(.ADDR_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .sel_1(sel_1),
        .rd_en_ram(rd_en_ram), .wr_en_ram(wr_en_ram), .address_ram(address_ram),
        .ram_hsize(ram_hsize), .wr_data(wr_data), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM stand-in: right-justified data, registered read, reset contents AA,BB,CC,DD,...
    logic [7:0] dev_mem [64];

    function automatic logic [7:0] init_byte(int i);
        return 8'(8'hAA + 17 * i);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 64; i++) dev_mem[i] <= init_byte(i);
            rd_data <= '0;
        end else begin
            if (sel_1 && wr_en_ram) begin
                for (int k = 0; k < 4; k++)
                    if (k < (1 << ram_hsize))
                        dev_mem[6'(address_ram[5:0] + 6'(k))] <= wr_data[8*k +: 8];
            end
            if (sel_1 && rd_en_ram) begin
                rd_data <= '0;
                for (int k = 0; k < 4; k++)
                    if (k < (1 << ram_hsize))
                        rd_data[8*k +: 8] <= dev_mem[6'(address_ram[5:0] + 6'(k))];
            end
        end
    end

    // Reference memory contents as the AHB master sees them.
    logic [7:0] ref_mem [64];

    task automatic ref_init();
        for (int i = 0; i < 64; i++) ref_mem[i] = init_byte(i);
    endtask

    function automatic logic [31:0] ref_read(logic [5:0] a, logic [2:0] s);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < (1 << s); k++) v[8*k +: 8] = ref_mem[6'(a + 6'(k))];
        return v;
    endfunction

    task automatic ref_write(logic [5:0] a, logic [2:0] s, logic [31:0] d);
        for (int k = 0; k < (1 << s); k++) ref_mem[6'(a + 6'(k))] = d[8*k +: 8];
    endtask

    function automatic bit is_legal(logic [31:0] a, logic [2:0] s);
        if (s > 3'd2) return 1'b0;
        if ((a >> 6) != 0) return 1'b0;
        if (s == 3'd1 && a[0]) return 1'b0;
        if (s == 3'd2 && a[1:0] != 2'b00) return 1'b0;
        return 1'b1;
    endfunction

    // Expected slave outputs per cycle.
    typedef struct packed {
        logic        ready;
        logic        resp;
        logic [31:0] rdata;
        logic        sel;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_a [0:2047];

    function automatic exp_t idle_v(logic [5:0] a, logic [2:0] s);
        exp_t e;
        e       = '0;
        e.ready = 1'b1;
        e.addr  = 32'(a);
        e.size  = s;
        return e;
    endfunction

    logic [5:0]  cap_a = '0;
    logic [2:0]  cap_s = '0;
    logic [31:0] next_hwdata = JUNK;

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Compare process: every cycle after reset release.
    initial begin
        exp_t g;
        exp_t e;
        wait (chk_en);
        forever begin
            @(negedge clk);
            #2;
            e = exp_a[cyc];
            g = '{hreadyout, hresp, hrdata, sel_1, rd_en_ram, wr_en_ram,
                  address_ram, ram_hsize, wr_data};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL cycle%0d outputs: got rdy=%0b resp=%0b rdata=%h sel=%0b rd=%0b wr=%0b addr=%h size=%0d wdata=%h expected rdy=%0b resp=%0b rdata=%h sel=%0b rd=%0b wr=%0b addr=%h size=%0d wdata=%h",
                         cyc, g.ready, g.resp, g.rdata, g.sel, g.rd, g.wr, g.addr, g.size, g.wdata,
                         e.ready, e.resp, e.rdata, e.sel, e.rd, e.wr, e.addr, e.size, e.wdata);
            end
        end
    end

    // One AHB address phase, held while the slave stalls; writes the predicted data phase.
    task automatic xfer(logic s_sel, logic [1:0] tr, logic wr, logic [2:0] sz,
                        logic [31:0] a, logic [31:0] wd);
        int  c;
        bit  done;
        done = 1'b0;
        while (!done) begin
            c           = cyc;
            hwdata      = next_hwdata;
            next_hwdata = JUNK;
            hsel   = s_sel;
            htrans = tr;
            hwrite = wr;
            hsize  = sz;
            haddr  = a;
            hready = exp_a[c].ready;
            if (exp_a[c].ready) begin
                done = 1'b1;
                exp_a[c+1] = idle_v(cap_a, cap_s);
                if (s_sel && tr[1]) begin
                    cap_a = a[5:0];
                    cap_s = sz;
                    exp_a[c+1] = idle_v(cap_a, cap_s);
                    if (is_legal(a, sz) && wr) begin
                        exp_a[c+1].sel   = 1'b1;
                        exp_a[c+1].wr    = 1'b1;
                        exp_a[c+1].wdata = wd;
                        next_hwdata      = wd;
                        ref_write(a[5:0], sz, wd);
                    end else if (is_legal(a, sz)) begin
                        exp_a[c+1].ready = 1'b0;
                        exp_a[c+1].sel   = 1'b1;
                        exp_a[c+1].rd    = 1'b1;
                        exp_a[c+2]       = idle_v(cap_a, cap_s);
                        exp_a[c+2].rdata = ref_read(a[5:0], sz);
                    end else begin
`ifdef AHB_RAM_ERR_RESP_EN
                        exp_a[c+1].ready = 1'b0;
                        exp_a[c+1].resp  = 1'b1;
                        exp_a[c+2]       = idle_v(cap_a, cap_s);
                        exp_a[c+2].resp  = 1'b1;
`endif
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic idle_cycles(int n);
        for (int i = 0; i < n; i++) xfer(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        for (int i = 0; i < 2048; i++) exp_a[i] = idle_v(6'd0, 3'd0);
        ref_init();
        reset_n = 1'b0;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
        haddr = '0; hwdata = JUNK; hready = 1'b1;

        // Reset values.
        #3;
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_strobes", 32'({sel_1, rd_en_ram, wr_en_ram}), 32'd0);
        chk("rst_address", address_ram, 32'd0);
        chk("rst_size", 32'(ram_hsize), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Model pins.
        chk("pin_byte01", ref_read(6'h01, 3'd0), 32'h0000_00BB);
        chk("pin_half02", ref_read(6'h02, 3'd1), 32'h0000_DDCC);
        chk("pin_illegal41", 32'(is_legal(32'h41, 3'd2)), 32'd0);
        chk("pin_illegal_half03", 32'(is_legal(32'h03, 3'd1)), 32'd0);

        idle_cycles(1);
        // Post-reset reads.
        xfer(1'b1, 2'b10, 1'b0, 3'd0, 32'h01, 32'h0);
        xfer(1'b1, 2'b10, 1'b0, 3'd1, 32'h02, 32'h0);
        idle_cycles(2);

        // Back-to-back word write then read of the same address.
        xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h08, 32'h1122_3344);
        chk("pin_word08", ref_read(6'h08, 3'd2), 32'h1122_3344);
        xfer(1'b1, 2'b11, 1'b0, 3'd2, 32'h08, 32'h0);
        idle_cycles(2);

        // Byte write into that word, read word back.
        xfer(1'b1, 2'b10, 1'b1, 3'd0, 32'h09, 32'h0000_00A5);
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h08, 32'h0);
        chk("pin_merge08", ref_read(6'h08, 3'd2), 32'h1122_A544);
        idle_cycles(1);

        // Top of the address range.
        xfer(1'b1, 2'b10, 1'b1, 3'd1, 32'h3E, 32'h0000_BEEF);
        xfer(1'b1, 2'b10, 1'b0, 3'd1, 32'h3E, 32'h0);
        xfer(1'b1, 2'b10, 1'b0, 3'd0, 32'h3F, 32'h0);
        idle_cycles(1);

        // Illegal transfers.
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h41, 32'h0);
        idle_cycles(2);
        xfer(1'b1, 2'b10, 1'b0, 3'd1, 32'h03, 32'h0);
        xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h0A, 32'h5555_5555);
        xfer(1'b1, 2'b10, 1'b0, 3'd3, 32'h00, 32'h0);
        xfer(1'b1, 2'b10, 1'b1, 3'd0, 32'h8000_0004, 32'h0000_0077);
        idle_cycles(1);

        // Write, illegal accepted in WR, read accepted right after, write held over a read stall.
        xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'hCAFE_F00D);
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h42, 32'h0);
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
        xfer(1'b1, 2'b10, 1'b1, 3'd1, 32'h12, 32'h0000_1234);
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
        idle_cycles(1);

        // No-capture cases: IDLE, BUSY, hsel=0 with NONSEQ.
        xfer(1'b1, 2'b00, 1'b1, 3'd2, 32'h20, 32'h0BAD_0001);
        xfer(1'b1, 2'b01, 1'b1, 3'd2, 32'h24, 32'h0BAD_0002);
        xfer(1'b0, 2'b10, 1'b1, 3'd2, 32'h28, 32'h0BAD_0003);
        xfer(1'b0, 2'b10, 1'b0, 3'd2, 32'h2C, 32'h0);
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'h0);
        idle_cycles(1);

        // Reset pulsed while a read sits in RD.
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h08, 32'h0);
        c      = cyc;
        hsel   = 1'b0;
        htrans = 2'b00;
        hready = exp_a[c].ready;
        hwdata = next_hwdata;
        next_hwdata = JUNK;
        exp_a[c+1] = idle_v(6'd0, 3'd0);
        #3;
        reset_n = 1'b0;
        ref_init();
        cap_a = '0;
        cap_s = '0;
        #1;
        chk("midrst_rd_en_drop", 32'(rd_en_ram), 32'd0);
        chk("midrst_sel_drop", 32'(sel_1), 32'd0);
        chk("midrst_hreadyout", 32'(hreadyout), 32'd1);
        @(negedge clk);
        c      = cyc;
        hready = 1'b1;
        exp_a[c+1] = idle_v(6'd0, 3'd0);
        #3;
        reset_n = 1'b1;
        @(negedge clk);

        xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h20, 32'h5A5A_1234);
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'h0);
        xfer(1'b1, 2'b10, 1'b0, 3'd0, 32'h01, 32'h0);
        idle_cycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
